// File: rtl/bmem_line_arbiter_if.sv
// Bundle of the I-side, D-side and banked-memory signals around the line arbiter.
// slave : the arbiter's view (takes client requests and memory returns).
// master: the environment's view (clients plus the banked memory).
interface bmem_line_arbiter_if;
  // I-side client
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  // D-side client
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  // banked memory
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  modport slave (
    input  i_addr, i_read,
    output i_rdata, i_resp,
    input  d_addr, d_read, d_write, d_wdata,
    output d_rdata, d_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output i_addr, i_read,
    input  i_rdata, i_resp,
    output d_addr, d_read, d_write, d_wdata,
    input  d_rdata, d_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_line_arbiter.sv
// Two-client (I/D) arbiter in front of a 64-bit banked memory.
// Moves 256-bit lines as four 64-bit beats, one memory transaction at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no transaction; grant one pending client (round-robin on tie)
// RD_ISSUE | bmem_read held with line address until bmem_ready
// RD_WAIT  | collect 4 tagged beats whose bmem_raddr matches the line
// WR_BURST | stream 4 write beats, advancing only when bmem_ready
// RESP     | one-cycle resp + rdata to the granted client
module bmem_line_arbiter (
  input logic           clk,
  input logic           rst,
  bmem_line_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t       state_q;
  logic         client_d_q;   // 0 = I-side, 1 = D-side
  logic         rr_d_q;       // 1 = D-side wins the next tie
  logic [1:0]   beat_q;
  logic [31:0]  line_addr_q;
  logic [255:0] line_q;

  logic [31:0]  bmem_addr_q;
  logic         bmem_read_q;
  logic         bmem_write_q;
  logic [63:0]  bmem_wdata_q;
  logic         i_resp_q;
  logic         d_resp_q;
  logic [255:0] i_rdata_q;
  logic [255:0] d_rdata_q;

  logic         i_req;
  logic         d_req;
  logic         grant_any;
  logic         grant_d;
  logic         grant_write;
  logic [31:0]  grant_line;
  logic [1:0]   beat_nxt;
  logic         beat_hit;

  // Grant selection and beat matching; read and write together on D counts as a write.
  always_comb begin
    i_req       = bus.i_read;
    d_req       = bus.d_read | bus.d_write;
    grant_any   = i_req | d_req;
    grant_d     = d_req & (~i_req | rr_d_q);
    grant_write = grant_d & bus.d_write;
    grant_line  = (grant_d ? bus.d_addr : bus.i_addr) & ~32'h0000_001F;
    beat_nxt    = beat_q + 2'd1;
    beat_hit    = bus.bmem_rvalid && (bus.bmem_raddr == line_addr_q);
  end

  // Single FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      client_d_q   <= 1'b0;
      rr_d_q       <= 1'b0;
      beat_q       <= 2'd0;
      line_addr_q  <= 32'd0;
      line_q       <= '0;
      bmem_addr_q  <= 32'd0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= 64'd0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            client_d_q  <= grant_d;
            rr_d_q      <= ~grant_d;
            line_addr_q <= grant_line;
            bmem_addr_q <= grant_line;
            beat_q      <= 2'd0;
            if (grant_write) begin
              line_q       <= bus.d_wdata;
              bmem_write_q <= 1'b1;
              bmem_wdata_q <= bus.d_wdata[63:0];
              state_q      <= WR_BURST;
            end else begin
              line_q      <= '0;
              bmem_read_q <= 1'b1;
              state_q     <= RD_ISSUE;
            end
          end
        end

        RD_ISSUE: begin
          if (bus.bmem_ready) begin
            bmem_read_q <= 1'b0;
            bmem_addr_q <= 32'd0;
            state_q     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // Beats tagged for any other line belong to someone else and are dropped.
          if (beat_hit) begin
            line_q[{beat_q, 6'd0} +: 64] <= bus.bmem_rdata;
            beat_q <= beat_nxt;
            if (beat_q == 2'd3) begin
              state_q <= RESP;
              if (client_d_q) begin
                d_resp_q  <= 1'b1;
                d_rdata_q <= {bus.bmem_rdata, line_q[191:0]};
              end else begin
                i_resp_q  <= 1'b1;
                i_rdata_q <= {bus.bmem_rdata, line_q[191:0]};
              end
            end
          end
        end

        WR_BURST: begin
          // A stalled beat keeps address and data unchanged.
          if (bus.bmem_ready) begin
            if (beat_q == 2'd3) begin
              bmem_write_q <= 1'b0;
              bmem_wdata_q <= 64'd0;
              bmem_addr_q  <= 32'd0;
              beat_q       <= 2'd0;
              state_q      <= RESP;
              if (client_d_q) begin
                d_resp_q  <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                i_resp_q  <= 1'b1;
                i_rdata_q <= '0;
              end
            end else begin
              beat_q       <= beat_nxt;
              bmem_wdata_q <= line_q[{beat_nxt, 6'd0} +: 64];
            end
          end
        end

        RESP: begin
          // No grant here: a request still high is taken as new in the following IDLE cycle.
          i_resp_q  <= 1'b0;
          d_resp_q  <= 1'b0;
          i_rdata_q <= '0;
          d_rdata_q <= '0;
          beat_q    <= 2'd0;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bmem_addr  = bmem_addr_q;
  assign bus.bmem_read  = bmem_read_q;
  assign bus.bmem_write = bmem_write_q;
  assign bus.bmem_wdata = bmem_wdata_q;
  assign bus.i_resp     = i_resp_q;
  assign bus.d_resp     = d_resp_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_rdata    = d_rdata_q;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bmem_read_q && bmem_write_q));
  a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(i_resp_q && d_resp_q));

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: hand-computed lines, addresses and grant order.
module tb_bmem_line_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  bmem_line_arbiter_if bus ();

  bmem_line_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the rising edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deliver_beats(input logic [31:0] a, input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = a;
      bus.bmem_rdata  = base + 64'(k);
      tick();
    end
    bus.bmem_rvalid = 1'b0;
    bus.bmem_raddr  = 32'd0;
    bus.bmem_rdata  = 64'd0;
  endtask

  // Waits for a read issue, answers it with beats base+0..base+3, returns at the RESP cycle.
  task automatic serve_read(input logic [63:0] base, input bit bad,
                            output logic [31:0] a, output int waited,
                            output logic gi, output logic gd, output logic [255:0] line);
    waited = 0;
    while (!bus.bmem_read && waited < 40) begin
      tick();
      waited++;
    end
    if (!bus.bmem_read) begin
      check_eq("rd_issue_timeout", 256'(bus.bmem_read), 256'd1);
      a = 32'd0; gi = 1'b0; gd = 1'b0; line = '0;
      return;
    end
    a = bus.bmem_addr;
    bus.bmem_ready = 1'b1;
    tick();
    check_eq("rd_issue_drop", 256'(bus.bmem_read), 256'd0);
    for (int k = 0; k < 4; k++) begin
      if (bad && k == 2) begin
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = a ^ 32'h0000_0100;
        bus.bmem_rdata  = 64'hBAD0_BAD0;
        tick();
      end
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = a;
      bus.bmem_rdata  = base + 64'(k);
      tick();
      if (k < 3) check_eq("resp_quiet_in_wait", 256'({bus.i_resp, bus.d_resp}), 256'd0);
    end
    bus.bmem_rvalid = 1'b0;
    bus.bmem_raddr  = 32'd0;
    bus.bmem_rdata  = 64'd0;
    gi   = bus.i_resp;
    gd   = bus.d_resp;
    line = gi ? bus.i_rdata : bus.d_rdata;
  endtask

  logic [31:0]  a;
  int           waited;
  logic         gi, gd;
  logic [255:0] line;
  logic [63:0]  wb [4];
  bit           rdy [7];
  int           wk;

  initial begin
    bus.i_addr = 32'd0; bus.i_read = 1'b0;
    bus.d_addr = 32'd0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_raddr = 32'd0; bus.bmem_rdata = 64'd0; bus.bmem_rvalid = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check_eq("rst_bmem_rw", 256'({bus.bmem_read, bus.bmem_write}), 256'd0);
    check_eq("rst_bmem_addr", 256'(bus.bmem_addr), 256'd0);
    check_eq("rst_resp", 256'({bus.i_resp, bus.d_resp}), 256'd0);
    check_eq("rst_i_rdata", bus.i_rdata, 256'd0);
    rst = 1'b0;
    tick();

    // I-read 0x1234_5678, beats A0..A3
    bus.i_addr = 32'h1234_5678; bus.i_read = 1'b1; bus.bmem_ready = 1'b1;
    serve_read(64'hA0, 1'b0, a, waited, gi, gd, line);
    check_eq("t1_grant_latency", 256'(waited), 256'd1);
    check_eq("t1_issue_addr", 256'(a), 256'h1234_5660);
    check_eq("t1_i_resp", 256'({gi, gd}), 256'b10);
    check_eq("t1_i_rdata", line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    bus.i_read = 1'b0;
    tick();
    check_eq("t1_resp_one_cycle", 256'(bus.i_resp), 256'd0);
    check_eq("t1_rdata_cleared", bus.i_rdata, 256'd0);

    // D-write 0x0000_1040 with beat 2 stalled 3 cycles
    wb[0] = 64'hD000_0000_0000_0000; wb[1] = 64'hD111_1111_1111_1111;
    wb[2] = 64'hD222_2222_2222_2222; wb[3] = 64'hD333_3333_3333_3333;
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.d_addr = 32'h0000_1040; bus.d_wdata = {wb[3], wb[2], wb[1], wb[0]};
    bus.d_write = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    wk = 0;
    for (int c = 0; c < 7; c++) begin
      bus.bmem_ready = rdy[c];
      check_eq("t2_write_hi", 256'({bus.bmem_write, bus.bmem_read}), 256'b10);
      check_eq("t2_addr_const", 256'(bus.bmem_addr), 256'h0000_1040);
      check_eq("t2_wdata", 256'(bus.bmem_wdata), 256'(wb[wk]));
      check_eq("t2_no_early_resp", 256'(bus.d_resp), 256'd0);
      if (rdy[c]) wk++;
      tick();
    end
    check_eq("t2_d_resp", 256'({bus.d_resp, bus.i_resp}), 256'b10);
    check_eq("t2_d_rdata_zero", bus.d_rdata, 256'd0);
    check_eq("t2_write_done", 256'(bus.bmem_write), 256'd0);
    bus.d_write = 1'b0; bus.bmem_ready = 1'b1;
    tick();
    check_eq("t2_resp_one_cycle", 256'(bus.d_resp), 256'd0);

    // I-read with a foreign-tagged beat injected mid-wait
    bus.i_addr = 32'h0000_ABCD; bus.i_read = 1'b1;
    serve_read(64'h500, 1'b1, a, waited, gi, gd, line);
    check_eq("t3_issue_addr", 256'(a), 256'h0000_ABC0);
    check_eq("t3_i_resp", 256'({gi, gd}), 256'b10);
    check_eq("t3_line_filtered", line, {64'h503, 64'h502, 64'h501, 64'h500});
    bus.i_read = 1'b0;
    tick();

    // D-read with bmem_ready low for 10 issue cycles; stray rvalid during issue
    bus.d_addr = 32'h8000_003F; bus.d_read = 1'b1; bus.bmem_ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      check_eq("t4_read_held", 256'(bus.bmem_read), 256'd1);
      check_eq("t4_addr_held", 256'(bus.bmem_addr), 256'h8000_0020);
      bus.bmem_rvalid = (c == 4);
      bus.bmem_raddr  = 32'h8000_0020;
      bus.bmem_rdata  = 64'hEE;
      tick();
    end
    bus.bmem_rvalid = 1'b0;
    bus.bmem_ready = 1'b1;
    tick();
    check_eq("t4_enter_wait", 256'(bus.bmem_read), 256'd0);
    deliver_beats(32'h8000_0020, 64'hC0, 4);
    check_eq("t4_d_resp", 256'({bus.d_resp, bus.i_resp}), 256'b10);
    check_eq("t4_d_rdata", bus.d_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    bus.d_read = 1'b0;
    tick();

    // Both clients reading continuously: grants alternate I, D, I, D
    bus.i_addr = 32'h0000_0100; bus.d_addr = 32'h0000_0200;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    for (int n = 0; n < 4; n++) begin
      serve_read(64'h10 * 64'(n + 1), 1'b0, a, waited, gi, gd, line);
      check_eq("t5_grant_addr", 256'(a), (n % 2 == 0) ? 256'h100 : 256'h200);
      check_eq("t5_resp_client", 256'({gi, gd}), (n % 2 == 0) ? 256'b10 : 256'b01);
      check_eq("t5_line", line, {64'h10 * 64'(n + 1) + 64'd3, 64'h10 * 64'(n + 1) + 64'd2,
                                 64'h10 * 64'(n + 1) + 64'd1, 64'h10 * 64'(n + 1)});
      if (n == 3) begin
        bus.i_read = 1'b0; bus.d_read = 1'b0;
      end
      tick();
      check_eq("t5_no_grant_in_resp", 256'(bus.bmem_read), 256'd0);
    end
    tick();

    // Reset after 2 beats of a D-read, then the stale beats arrive
    bus.d_addr = 32'h0000_4000; bus.d_read = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    check_eq("t6_issue", 256'(bus.bmem_read), 256'd1);
    tick();
    deliver_beats(32'h0000_4000, 64'h70, 2);
    bus.d_read = 1'b0; rst = 1'b1;
    tick();
    check_eq("t6_rst_outputs", 256'({bus.bmem_read, bus.bmem_write, bus.d_resp, bus.i_resp}), 256'd0);
    rst = 1'b0;
    deliver_beats(32'h0000_4000, 64'h72, 2);
    check_eq("t6_no_d_resp", 256'(bus.d_resp), 256'd0);
    check_eq("t6_idle", 256'({bus.bmem_read, bus.bmem_write}), 256'd0);
    tick();
    check_eq("t6_still_quiet", 256'({bus.d_resp, bus.i_resp}), 256'd0);
    bus.i_addr = 32'h0000_4004; bus.i_read = 1'b1;
    serve_read(64'h90, 1'b0, a, waited, gi, gd, line);
    check_eq("t6_next_addr", 256'(a), 256'h0000_4000);
    check_eq("t6_next_resp", 256'({gi, gd}), 256'b10);
    check_eq("t6_next_line", line, {64'h93, 64'h92, 64'h91, 64'h90});
    bus.i_read = 1'b0;
    tick();

    // d_read and d_write together: the write wins
    bus.d_addr = 32'h0000_0060; bus.d_read = 1'b1; bus.d_write = 1'b1;
    bus.d_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
    tick();
    check_eq("t7_write_wins", 256'({bus.bmem_write, bus.bmem_read}), 256'b10);
    check_eq("t7_wdata0", 256'(bus.bmem_wdata), 256'h1);
    tick(); tick(); tick(); tick();
    check_eq("t7_d_resp", 256'(bus.d_resp), 256'd1);
    check_eq("t7_d_rdata_zero", bus.d_rdata, 256'd0);
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bmem_line_arbiter.md
BMEM_LINE_ARBITER -- requirements
Module: bmem_line_arbiter

Interface
REQ-001 SHALL have ports `clk` (in, 1, sole clock, rising edge) and `rst` (in, 1); reset is synchronous and active-high.
REQ-002 SHALL have I-side ports:
- `i_addr` (in, 32): byte address.
- `i_read` (in, 1): level read request, held until `i_resp`.
- `i_rdata` (out, 256): read line.
- `i_resp` (out, 1): one-cycle completion pulse.
REQ-003 SHALL have D-side ports:
- `d_addr` (in, 32) and `d_read` (in, 1), same meanings as the I-side.
- `d_write` (in, 1): level write request, held until `d_resp`.
- `d_wdata` (in, 256): write line.
- `d_rdata` (out, 256): read line.
- `d_resp` (out, 1): one-cycle completion pulse.
REQ-004 SHALL have banked-memory ports:
- `bmem_addr` (out, 32), `bmem_read` (out, 1), `bmem_write` (out, 1), `bmem_wdata` (out, 64).
- `bmem_ready` (in, 1).
- `bmem_raddr` (in, 32), `bmem_rdata` (in, 64), `bmem_rvalid` (in, 1): tagged read-return beats.

Function
REQ-005 SHALL run one FSM with states IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP.
REQ-006 SHALL have at most one bmem transaction outstanding.
REQ-007 In IDLE SHALL grant one pending client per cycle:
- Requests are `i_read`, `d_read`, `d_write`.
- If both clients request, round-robin; pointer starts at I and flips to the other client after each grant.
- On grant, latch client id, line address {addr[31:5], 5'b0} and, for writes, `d_wdata`.
REQ-008 SHALL treat `d_read`&`d_write` together as a client protocol error; the write takes precedence.
REQ-009 Read grant SHALL go to RD_ISSUE.
- `bmem_read`=1 and `bmem_addr`=latched line address.
- Leave RD_ISSUE for RD_WAIT on the first cycle with `bmem_ready`=1.
REQ-010 In RD_WAIT SHALL accept a beat only when `bmem_rvalid`=1 and `bmem_raddr`=latched line address.
- Beats with any other `bmem_raddr` SHALL be ignored.
- Beat k (k=0..3, arrival order) SHALL be written to line bits [64k+63:64k] using a 2-bit counter.
- Acceptance of beat 3 SHALL move the FSM to RESP.
REQ-011 Write grant SHALL go to WR_BURST.
- `bmem_write`=1, `bmem_addr`=line address held constant, `bmem_wdata`=beat k of the latched line.
- k advances only on cycles with `bmem_ready`=1; a stalled beat is held unchanged.
- Beat 3 accepted SHALL move the FSM to RESP.
REQ-012 In RESP SHALL, for exactly one cycle:
- assert the granted client's `resp`;
- drive the assembled line on that client's `rdata` (all zeros for writes);
- then return to IDLE.
REQ-013 Minimum latency, grant to resp:
- Read: 1 issue cycle + 4 beat cycles + 1 RESP cycle = 6 cycles when memory answers immediately.
- Write: 4 + 1 = 5 cycles with `bmem_ready` constantly high.
REQ-014 Outside RESP, `i_resp`/`d_resp` SHALL be 0.
REQ-015 `rdata` SHALL be valid only in the RESP cycle.
REQ-016 `bmem_read` and `bmem_write` SHALL never be high in the same cycle.
REQ-017 `bmem_read` SHALL be high only in RD_ISSUE; `bmem_write` only in WR_BURST.
REQ-018 `bmem_rvalid` in IDLE, RD_ISSUE, WR_BURST or RESP SHALL be ignored and SHALL NOT modify state.
REQ-019 A client request still asserted in the cycle after its RESP SHALL be treated as a new request.
REQ-020 A new request SHALL NOT be granted in the RESP cycle itself.

Reset
REQ-021 While `rst`=1, on every rising edge:
- state=IDLE, beat counter=0, round-robin pointer=I;
- all outputs 0 (`bmem_*`, `i_resp`, `d_resp`, `i_rdata`, `d_rdata`).
REQ-022 Reset asserted mid-transaction SHALL abandon it without issuing `resp`.
- Beats of the abandoned read arriving after reset SHALL be dropped per REQ-018.

Verification
REQ-023 I-read of 0x1234_5678, memory returns beats 0xA0..0xA3 with `bmem_raddr`=0x1234_5660:
- `bmem_addr`=0x1234_5660 during issue;
- `i_rdata`={0xA3,0xA2,0xA1,0xA0} (each beat zero-extended to 64 bits) with a 1-cycle `i_resp`.
REQ-024 D-write of 0x0000_1040 with `bmem_ready` low on beat 2 for 3 cycles:
- 4 accepted beats in order with beat 2 held for 3 stall cycles;
- `bmem_addr` constant at 0x0000_1040;
- `d_resp` in the cycle after beat 3 is accepted.
REQ-025 `i_read` and `d_read` asserted together, and asserted again after each resp:
- grants alternate I, D, I, D;
- never two consecutive grants to the same client while both are pending.
REQ-026 During RD_WAIT, inject a `bmem_rvalid` beat with `bmem_raddr`≠line address:
- the beat is ignored;
- the final line contains only the 4 matching beats.
REQ-027 Assert `rst` after 2 beats of a D-read, then deliver the remaining 2 beats:
- no `d_resp`;
- FSM in IDLE;
- the next I-read completes correctly.
REQ-028 `bmem_ready` held low 10 cycles in RD_ISSUE:
- `bmem_read` stays 1 with constant address;
- RD_WAIT is entered on the cycle after `bmem_ready` rises.
